stack_unit: RTL and testbench

- Sequencer for register-pair PUSH/POP between the 8-register file and byte-wide memory.
- On the register-file side it drives the read select, write select, write data and write enable, and consumes the register file's combinational read data.
- Owns the 16-bit stack pointer (SP) and runs a request/ready memory handshake.
- Sits between the instruction decoder, which issues commands, and the register file and memory bus.

---
 rtl/stack_unit_pkg.sv | 31 +++
 rtl/pair_decode.sv | 21 ++
 rtl/stack_unit.sv | 133 +++++++++++++
 tb/tb_stack_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// Shared encodings for the PUSH/POP stack sequencer: register indices,
// pair and op codes, and the FSM state type.
package stack_unit_pkg;

    localparam logic [2:0] REG_A    = 3'd0;
    localparam logic [2:0] REG_B    = 3'd1;
    localparam logic [2:0] REG_C    = 3'd2;
    localparam logic [2:0] REG_D    = 3'd3;
    localparam logic [2:0] REG_E    = 3'd4;
    localparam logic [2:0] REG_H    = 3'd5;
    localparam logic [2:0] REG_L    = 3'd6;
    localparam logic [2:0] REG_RSVD = 3'd7;

    localparam logic [1:0] PAIR_BC = 2'b00;
    localparam logic [1:0] PAIR_DE = 2'b01;
    localparam logic [1:0] PAIR_HL = 2'b10;
    localparam logic [1:0] PAIR_AR = 2'b11;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_POP_LO,
        ST_POP_HI,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pair_decode.sv
// Maps a register-pair code to its high and low register-file indices.
module pair_decode
    import stack_unit_pkg::*;
(
    input  logic [1:0] pair_i,
    output logic [2:0] hi_sel_o,
    output logic [2:0] lo_sel_o
);

    always_comb begin
        hi_sel_o = REG_A;
        lo_sel_o = REG_RSVD;
        unique case (pair_i)
            PAIR_BC: begin hi_sel_o = REG_B; lo_sel_o = REG_C;    end
            PAIR_DE: begin hi_sel_o = REG_D; lo_sel_o = REG_E;    end
            PAIR_HL: begin hi_sel_o = REG_H; lo_sel_o = REG_L;    end
            PAIR_AR: begin hi_sel_o = REG_A; lo_sel_o = REG_RSVD; end
        endcase
    end

endmodule

// File: rtl/stack_unit.sv
// Register-pair PUSH/POP sequencer: owns SP, drives the register file and
// a request/ready byte memory port. PUSH writes hi then lo downward; POP reads lo then hi upward.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter logic [15:0] SP_RESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_pair,
    input  logic        sp_load,
    input  logic [15:0] sp_load_val,
    output logic [15:0] sp_out,
    output logic        busy,
    output logic        done,
    output logic [2:0]  rf_read_sel,
    input  logic [7:0]  rf_rd_data,
    output logic [2:0]  rf_write_sel,
    output logic [7:0]  rf_wdata,
    output logic        rf_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    state_e      state_q;
    logic [15:0] sp_q;
    logic [2:0]  hi_q, lo_q;
    logic [2:0]  rd_sel_q, wr_sel_q;
    logic [7:0]  rf_wdata_q;
    logic        rf_we_q, done_q;
    logic [15:0] addr_q;
    logic        req_q, we_q;
    logic [2:0]  hi_sel, lo_sel;

    pair_decode u_pair_decode (
        .pair_i   (cmd_pair),
        .hi_sel_o (hi_sel),
        .lo_sel_o (lo_sel)
    );

    assign cmd_ready    = (state_q == ST_IDLE) && !sp_load;
    assign busy         = (state_q != ST_IDLE);
    assign sp_out       = sp_q;
    assign done         = done_q;
    assign rf_read_sel  = rd_sel_q;
    assign rf_write_sel = wr_sel_q;
    assign rf_wdata     = rf_wdata_q;
    assign rf_we        = rf_we_q;
    assign mem_addr     = addr_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    // Register data flows straight through; rd_sel_q is held during wait states.
    assign mem_wdata    = (state_q == ST_PUSH_HI || state_q == ST_PUSH_LO) ? rf_rd_data : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sp_q       <= SP_RESET;
            hi_q       <= 3'd0;
            lo_q       <= 3'd0;
            rd_sel_q   <= 3'd0;
            wr_sel_q   <= 3'd0;
            rf_wdata_q <= 8'h00;
            rf_we_q    <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= 16'h0000;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (sp_load) begin
                        sp_q <= sp_load_val;
                    end else if (cmd_valid) begin
                        hi_q  <= hi_sel;
                        lo_q  <= lo_sel;
                        req_q <= 1'b1;
                        if (cmd_op == OP_PUSH) begin
                            state_q  <= ST_PUSH_HI;
                            addr_q   <= sp_q - 16'd1;
                            rd_sel_q <= hi_sel;
                            we_q     <= 1'b1;
                        end else begin
                            state_q <= ST_POP_LO;
                            addr_q  <= sp_q;
                            we_q    <= 1'b0;
                        end
                    end
                end
                ST_PUSH_HI: if (mem_ready) begin
                    state_q  <= ST_PUSH_LO;
                    addr_q   <= sp_q - 16'd2;
                    rd_sel_q <= lo_q;
                end
                ST_PUSH_LO: if (mem_ready) begin
                    state_q <= ST_DONE;
                    sp_q    <= sp_q - 16'd2;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_POP_LO: if (mem_ready) begin
                    state_q    <= ST_POP_HI;
                    rf_wdata_q <= mem_rdata;
                    wr_sel_q   <= lo_q;
                    rf_we_q    <= 1'b1;
                    addr_q     <= sp_q + 16'd1;
                end
                ST_POP_HI: if (mem_ready) begin
                    state_q    <= ST_DONE;
                    rf_wdata_q <= mem_rdata;
                    wr_sel_q   <= hi_q;
                    rf_we_q    <= 1'b1;
                    sp_q       <= sp_q + 16'd2;
                    req_q      <= 1'b0;
                    done_q     <= 1'b1;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: stimulus queues expected memory beats and
// register writes; a monitor compares them whenever the DUT presents them.
module tb_stack_unit;
    import stack_unit_pkg::*;

    typedef struct { logic we; logic [15:0] addr; logic [7:0] data; } mexp_t;
    typedef struct { logic [2:0] sel; logic [7:0] data; } rexp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_op = 1'b0, sp_load = 1'b0;
    logic [1:0]  cmd_pair = 2'b00;
    logic [15:0] sp_load_val = 16'h0000;
    logic        cmd_ready, busy, done, rf_we, mem_req, mem_we;
    logic [15:0] sp_out, mem_addr;
    logic [2:0]  rf_read_sel, rf_write_sel;
    logic [7:0]  rf_rd_data, rf_wdata, mem_wdata, mem_rdata;
    logic        mem_ready = 1'b1;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rf  [0:7];
    mexp_t       mq[$];
    rexp_t       rq[$];
    int          errors = 0, checks = 0, stall_n = 0, wcnt = 0;

    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_read_sel];
    assign mem_rdata  = mem[mem_addr];

    stack_unit #(.SP_RESET(16'hFFFF)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pair(cmd_pair),
        .sp_load(sp_load), .sp_load_val(sp_load_val), .sp_out(sp_out),
        .busy(busy), .done(done),
        .rf_read_sel(rf_read_sel), .rf_rd_data(rf_rd_data),
        .rf_write_sel(rf_write_sel), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory and register-file models.
    initial begin
        rf[0] = 8'h9A; rf[1] = 8'h12; rf[2] = 8'h34; rf[3] = 8'h56;
        rf[4] = 8'h78; rf[5] = 8'h00; rf[6] = 8'h00; rf[7] = 8'hBC;
        mem[16'h0000] = 8'h22;
        forever begin
            @(posedge clk);
            if (reset && mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
            if (reset && rf_we) rf[rf_write_sel] = rf_wdata;
        end
    end

    // Inserts stall_n wait cycles ahead of every memory beat.
    initial forever begin
        @(negedge clk);
        if (mem_req && wcnt < stall_n) begin
            mem_ready = 1'b0;
            wcnt++;
        end else begin
            mem_ready = 1'b1;
            wcnt = 0;
        end
    end

    // Monitor: every cycle with a request must match the head beat.
    initial forever begin
        @(negedge clk);
        #1;
        if (reset) begin
            if (mem_req) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: got addr %0h we %0b, no beat expected", mem_addr, mem_we);
                end else begin
                    chk("mem_we", mem_we, mq[0].we);
                    chk("mem_addr", mem_addr, mq[0].addr);
                    if (mq[0].we) chk("mem_wdata", mem_wdata, mq[0].data);
                    if (mem_ready) void'(mq.pop_front());
                end
            end
            if (rf_we) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rf_unexpected: got sel %0d data %0h, no write expected", rf_write_sel, rf_wdata);
                end else begin
                    chk("rf_sel", rf_write_sel, rq[0].sel);
                    chk("rf_data", rf_wdata, rq[0].data);
                    void'(rq.pop_front());
                end
            end
        end
    end

    task automatic load_sp(input logic [15:0] v);
        @(negedge clk);
        sp_load = 1'b1; sp_load_val = v;
        @(negedge clk);
        sp_load = 1'b0;
    endtask

    task automatic mexp(input logic we, input logic [15:0] a, input logic [7:0] d);
        mq.push_back('{we, a, d});
    endtask

    task automatic rexp(input logic [2:0] s, input logic [7:0] d);
        rq.push_back('{s, d});
    endtask

    task automatic run_cmd(input logic op, input logic [1:0] pair, input int exp_cyc,
                           input logic [15:0] exp_sp, input int load_at, input string nm);
        int cyc;
        @(negedge clk);
        chk({nm, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_pair = pair;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc == load_at) begin sp_load = 1'b1; sp_load_val = 16'h5555; end
            @(negedge clk);
            sp_load = 1'b0;
            cyc++;
        end
        chk({nm, "_done_cyc"}, cyc, exp_cyc);
        chk({nm, "_sp"}, sp_out, exp_sp);
        @(negedge clk);
        chk({nm, "_idle"}, {busy, cmd_ready}, 2'b01);
        chk({nm, "_mq_left"}, mq.size(), 0);
        chk({nm, "_rq_left"}, rq.size(), 0);
        mq.delete(); rq.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sp", sp_out, 16'hFFFF);
        chk("rst_req", mem_req, 0);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_rf", {rf_we, rf_read_sel, rf_write_sel, rf_wdata}, 0);
        chk("rst_mem", {mem_we, mem_addr}, 0);
        chk("rst_ready", cmd_ready, 1);

        // sp_load wins over a simultaneous command
        @(negedge clk);
        sp_load = 1'b1; sp_load_val = 16'h1234;
        cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_pair = PAIR_BC;
        #1 chk("ld_ready", cmd_ready, 0);
        @(negedge clk);
        sp_load = 1'b0; cmd_valid = 1'b0;
        chk("ld_sp", sp_out, 16'h1234);
        chk("ld_busy", busy, 0);

        // Asynchronous reset in the middle of a stalled PUSH
        stall_n = 100;
        mexp(1'b1, 16'h1233, 8'h12);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_pair = PAIR_BC;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_req_before", mem_req, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_req", mem_req, 0);
        chk("mid_busy", busy, 0);
        chk("mid_sp", sp_out, 16'hFFFF);
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        stall_n = 0;

        load_sp(16'h2000);
        mexp(1'b1, 16'h1FFF, 8'h12); mexp(1'b1, 16'h1FFE, 8'h34);
        run_cmd(OP_PUSH, PAIR_BC, 3, 16'h1FFE, 0, "push_bc");

        mexp(1'b0, 16'h1FFE, 8'h00); mexp(1'b0, 16'h1FFF, 8'h00);
        rexp(REG_L, 8'h34); rexp(REG_H, 8'h12);
        run_cmd(OP_POP, PAIR_HL, 3, 16'h2000, 0, "pop_hl");

        stall_n = 3;
        mexp(1'b1, 16'h1FFF, 8'h56); mexp(1'b1, 16'h1FFE, 8'h78);
        run_cmd(OP_PUSH, PAIR_DE, 9, 16'h1FFE, 0, "push_de_wait");
        stall_n = 0;

        load_sp(16'h0000);
        mexp(1'b1, 16'hFFFF, 8'h9A); mexp(1'b1, 16'hFFFE, 8'hBC);
        run_cmd(OP_PUSH, PAIR_AR, 3, 16'hFFFE, 0, "push_wrap");

        load_sp(16'hFFFF);
        mexp(1'b0, 16'hFFFF, 8'h00); mexp(1'b0, 16'h0000, 8'h00);
        rexp(REG_C, 8'h9A); rexp(REG_B, 8'h22);
        run_cmd(OP_POP, PAIR_BC, 3, 16'h0001, 0, "pop_wrap");

        // sp_load pulsed while busy must be ignored
        stall_n = 2;
        mexp(1'b1, 16'h0000, 8'h12); mexp(1'b1, 16'hFFFF, 8'h34);
        run_cmd(OP_PUSH, PAIR_HL, 7, 16'hFFFF, 2, "push_ld_busy");
        stall_n = 0;

        mexp(1'b0, 16'hFFFF, 8'h00); mexp(1'b0, 16'h0000, 8'h00);
        rexp(REG_RSVD, 8'h34); rexp(REG_A, 8'h12);
        run_cmd(OP_POP, PAIR_AR, 3, 16'h0001, 0, "pop_ar");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
